// File: rtl/alu_param_pipe.sv
// Registered, parametrised ALU with a valid/ready input handshake.
// Divides run on an iterative restoring divider; every other opcode completes one cycle after acceptance.
module alu_param_pipe #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned SHIFT_MODE = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [WIDTH-1:0] MUL_HI,
  output logic             Carry_Flag,
  output logic             Arith_flag,
  output logic             Logic_flag,
  output logic             CMP_flag,
  output logic             Shift_flag,
  output logic             Zero_Flag,
  output logic             Div_Zero_Flag,
  output logic             OUT_VALID
);

  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e state_q, state_d;

  logic             accept, start_div;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic             cap_q;

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [SW-1:0]    cnt_q;
  logic [WIDTH:0]   shifted, sub;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   res, hi;
  logic               carry, arith, logic_c, cmp, shift, dz;

  assign IN_READY  = (state_q == StIdle);
  assign accept    = IN_VALID & IN_READY;
  // Only a divide with a non-zero divisor goes through the iterative path.
  assign start_div = accept && (ALU_FUN == 4'b0011) && (B != '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_div) state_d = StDiv;
      StDiv:  if (cnt_q == SW'(WIDTH - 1)) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cap_q <= 1'b0;
    end else begin
      cap_q <= accept && !start_div;
      if (accept && !start_div) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= ALU_FUN;
      end
    end
  end

  // Restoring divide step: partial remainder never exceeds the divisor, so WIDTH+1 bits suffice.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    sub     = shifted - {1'b0, dvs_q};
    ge      = (shifted >= {1'b0, dvs_q});
    rem_nxt = ge ? sub[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start_div) begin
      rem_q <= '0;
      quo_q <= A;
      dvs_q <= B;
      cnt_q <= '0;
    end else if (state_q == StDiv) begin
      rem_q <= rem_nxt;
      quo_q <= {quo_q[WIDTH-2:0], ge};
      cnt_q <= cnt_q + SW'(1);
    end
  end

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    prod    = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    shamt   = (SHIFT_MODE != 0) ? b_q[SW-1:0] : SW'(1);
    res     = '0;
    hi      = '0;
    carry   = 1'b0;
    arith   = 1'b0;
    logic_c = 1'b0;
    cmp     = 1'b0;
    shift   = 1'b0;
    dz      = 1'b0;
    unique case (op_q)
      4'b0000: begin res = sum[WIDTH-1:0]; carry = sum[WIDTH]; arith = 1'b1; end
      4'b0001: begin res = a_q - b_q; carry = (a_q < b_q); arith = 1'b1; end
      4'b0010: begin res = prod[WIDTH-1:0]; hi = prod[2*WIDTH-1:WIDTH]; arith = 1'b1; end
      // Only the zero-divisor case reaches this path.
      4'b0011: begin res = '1; dz = 1'b1; arith = 1'b1; end
      4'b0100: begin res = a_q & b_q; logic_c = 1'b1; end
      4'b0101: begin res = a_q | b_q; logic_c = 1'b1; end
      4'b0110: begin res = ~(a_q & b_q); logic_c = 1'b1; end
      4'b0111: begin res = ~(a_q | b_q); logic_c = 1'b1; end
      4'b1000: begin res = a_q ^ b_q; logic_c = 1'b1; end
      4'b1001: begin res = ~(a_q ^ b_q); logic_c = 1'b1; end
      4'b1010: begin res = (a_q == b_q) ? WIDTH'(1) : '0; cmp = 1'b1; end
      4'b1011: begin res = (a_q > b_q) ? WIDTH'(2) : '0; cmp = 1'b1; end
      4'b1100: begin res = (a_q < b_q) ? WIDTH'(3) : '0; cmp = 1'b1; end
      4'b1101: begin res = a_q >> shamt; shift = 1'b1; end
      4'b1110: begin res = a_q << shamt; shift = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ALU_OUT       <= '0;
      MUL_HI        <= '0;
      Carry_Flag    <= 1'b0;
      Arith_flag    <= 1'b0;
      Logic_flag    <= 1'b0;
      CMP_flag      <= 1'b0;
      Shift_flag    <= 1'b0;
      Zero_Flag     <= 1'b0;
      Div_Zero_Flag <= 1'b0;
      OUT_VALID     <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      if (state_q == StDone) begin
        ALU_OUT       <= quo_q;
        MUL_HI        <= '0;
        Carry_Flag    <= 1'b0;
        Arith_flag    <= 1'b1;
        Logic_flag    <= 1'b0;
        CMP_flag      <= 1'b0;
        Shift_flag    <= 1'b0;
        Zero_Flag     <= (quo_q == '0);
        Div_Zero_Flag <= 1'b0;
        OUT_VALID     <= 1'b1;
      end else if (cap_q) begin
        ALU_OUT       <= res;
        MUL_HI        <= hi;
        Carry_Flag    <= carry;
        Arith_flag    <= arith;
        Logic_flag    <= logic_c;
        CMP_flag      <= cmp;
        Shift_flag    <= shift;
        Zero_Flag     <= (res == '0);
        Div_Zero_Flag <= dz;
        OUT_VALID     <= 1'b1;
      end
    end
  end

endmodule
